// File: rtl/jtframe_cheat_sdram_arb_if.sv
// SDRAM bank-0 request bus between the cheat arbiter and the bank controller.
interface jtframe_cheat_sdram_arb_if #(
    parameter int AW = 22
);
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [15:0]   din;
    logic [1:0]    din_m;
    logic          ack;
    logic          dst;
    logic          rdy;
    logic [15:0]   data_read;

    modport master (
        output addr, rd, wr, din, din_m,
        input  ack, dst, rdy, data_read
    );

    modport slave (
        input  addr, rd, wr, din, din_m,
        output ack, dst, rdy, data_read
    );
endinterface

// File: rtl/jtframe_cheat_sdram_arb.sv
// Bank-0 arbiter: game has priority, cheat port wins after a starvation guard.
// A grant that never sees ba0_rdy is aborted after TOUT cycles.
module jtframe_cheat_sdram_arb #(
    parameter int AW      = 22,
    parameter int MAXWAIT = 64,
    parameter int TOUT    = 255
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          lock,
    input  logic [AW-1:0] game_addr,
    input  logic          game_rd,
    input  logic          game_wr,
    input  logic [15:0]   game_din,
    input  logic [1:0]    game_din_m,
    output logic          game_ack,
    output logic          game_dst,
    output logic          game_rdy,
    input  logic          pico_req,
    input  logic          pico_wr,
    input  logic [23:0]   pico_addr,
    input  logic [15:0]   pico_din,
    input  logic [1:0]    pico_din_m,
    output logic [15:0]   pico_dout,
    output logic          pico_busy,
    output logic          pico_rdy,
    output logic          pico_err,
    jtframe_cheat_sdram_arb_if.master ba0
);
    localparam int WW = $clog2(MAXWAIT + 1);
    localparam int TW = $clog2(TOUT + 1);

    typedef enum logic [1:0] { IDLE, GAME, PICO } state_t;

    state_t        state;
    logic          pend;
    logic          wr_l;
    logic [AW-1:0] addr_l;
    logic [15:0]   din_l;
    logic [1:0]    din_m_l;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] tout_cnt;

    logic in_game;
    logic in_pico;
    logic game_req;
    logic guard;
    logic tout;
    logic pico_end;
    logic accept;
    logic unused_addr;

    assign in_game  = state == GAME;
    assign in_pico  = state == PICO;
    assign game_req = game_rd | game_wr;
    assign guard    = wait_cnt == WW'(MAXWAIT);
    assign tout     = tout_cnt == TW'(TOUT - 1);
    assign pico_end = in_pico & (ba0.rdy | tout);
    // a request arriving as the current cheat transfer ends is kept
    assign accept   = pico_req & ~lock & (~pico_busy | pico_end);

    assign unused_addr = &{1'b0, pico_addr[23:AW]};

    assign ba0.addr  = in_game ? game_addr  : in_pico ? addr_l  : '0;
    assign ba0.din   = in_game ? game_din   : in_pico ? din_l   : '0;
    assign ba0.din_m = in_game ? game_din_m : in_pico ? din_m_l : '0;
    assign ba0.rd    = in_game ? game_rd : in_pico & pend & ~wr_l;
    assign ba0.wr    = in_game ? game_wr : in_pico & pend &  wr_l;

    assign game_ack = in_game & ba0.ack;
    assign game_dst = in_game & ba0.dst;
    assign game_rdy = in_game & ba0.rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= 1'b0;
            wr_l      <= 1'b0;
            addr_l    <= '0;
            din_l     <= '0;
            din_m_l   <= '0;
            wait_cnt  <= '0;
            tout_cnt  <= '0;
            pico_dout <= '0;
            pico_busy <= 1'b0;
            pico_rdy  <= 1'b0;
            pico_err  <= 1'b0;
        end else begin
            pico_rdy <= 1'b0;
            tout_cnt <= tout_cnt + TW'(1);
            if (accept) begin
                wr_l      <= pico_wr;
                addr_l    <= pico_addr[AW-1:0];
                din_l     <= pico_din;
                din_m_l   <= pico_din_m;
                pico_busy <= 1'b1;
                pico_err  <= 1'b0;
            end
            if (pico_busy && !in_pico && !guard)
                wait_cnt <= wait_cnt + WW'(1);
            unique case (state)
                IDLE: begin
                    tout_cnt <= '0;
                    if (game_req && !guard) begin
                        state <= GAME;
                    end else if (pico_busy) begin
                        state    <= PICO;
                        pend     <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                GAME: begin
                    if (ba0.rdy || tout) begin
                        state    <= IDLE;
                        tout_cnt <= '0;
                    end
                end
                PICO: begin
                    if (ba0.ack)
                        pend <= 1'b0;
                    if (ba0.dst && !wr_l)
                        pico_dout <= ba0.data_read;
                    if (pico_end) begin
                        state    <= IDLE;
                        pend     <= 1'b0;
                        tout_cnt <= '0;
                        pico_rdy <= 1'b1;
                        if (!accept)
                            pico_busy <= 1'b0;
                        if (tout && !ba0.rdy)
                            pico_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_cheat_sdram_arb.sv
// Bench for the bank-0 cheat arbiter: SDRAM responder, drivers and a
// scoreboard that checks each completed transfer against queued expectations.
module tb_jtframe_cheat_sdram_arb;
    localparam int AW      = 22;
    localparam int MAXWAIT = 64;
    localparam int TOUT    = 255;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    m;
    } txn_t;

    typedef struct packed {
        txn_t t;
        logic err;
    } pexp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lock = 1'b0;
    logic [AW-1:0] game_addr = '0;
    logic          game_rd = 1'b0;
    logic          game_wr = 1'b0;
    logic [15:0]   game_din = '0;
    logic [1:0]    game_din_m = '0;
    logic          game_ack, game_dst, game_rdy;
    logic          pico_req = 1'b0;
    logic          pico_wr = 1'b0;
    logic [23:0]   pico_addr = '0;
    logic [15:0]   pico_din = '0;
    logic [1:0]    pico_din_m = '0;
    logic [15:0]   pico_dout;
    logic          pico_busy, pico_rdy, pico_err;

    jtframe_cheat_sdram_arb_if #(.AW(AW)) ba0();

    jtframe_cheat_sdram_arb #(.AW(AW), .MAXWAIT(MAXWAIT), .TOUT(TOUT)) dut (
        .rst(rst), .clk(clk), .lock(lock),
        .game_addr(game_addr), .game_rd(game_rd), .game_wr(game_wr),
        .game_din(game_din), .game_din_m(game_din_m),
        .game_ack(game_ack), .game_dst(game_dst), .game_rdy(game_rdy),
        .pico_req(pico_req), .pico_wr(pico_wr), .pico_addr(pico_addr),
        .pico_din(pico_din), .pico_din_m(pico_din_m),
        .pico_dout(pico_dout), .pico_busy(pico_busy),
        .pico_rdy(pico_rdy), .pico_err(pico_err),
        .ba0(ba0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // SDRAM contents: a fixed hash unless overridden
    logic [15:0] mem [logic [AW-1:0]];

    function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ {a[21:16], a[9:0]} ^ 16'h5A3C;
    endfunction

    int   r_cnt = -1;
    int   r_ack, r_dst, r_rdy;
    txn_t r_txn, last_txn;
    int   cap_cyc = 0;
    bit   drop_rdy = 1'b0;
    bit   fixed_dly = 1'b0;

    initial begin
        ba0.ack = 1'b0;
        ba0.dst = 1'b0;
        ba0.rdy = 1'b0;
        ba0.data_read = '0;
        forever begin
            @(posedge clk); #1;
            ba0.ack = 1'b0;
            ba0.dst = 1'b0;
            ba0.rdy = 1'b0;
            ba0.data_read = 16'($urandom);
            if (rst) begin
                r_cnt = -1;
            end else if (r_cnt >= 0) begin
                r_cnt++;
                if (r_cnt == r_ack) ba0.ack = 1'b1;
                if (r_cnt == r_dst && !r_txn.wr) begin
                    ba0.dst = 1'b1;
                    ba0.data_read = mem_rd(r_txn.addr);
                end
                if (r_cnt == r_rdy) begin
                    ba0.rdy = !drop_rdy;
                    r_cnt = -1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && r_cnt < 0 && (ba0.rd || ba0.wr)) begin
            r_txn = {ba0.wr, ba0.addr, ba0.din, ba0.din_m};
            last_txn = r_txn;
            cap_cyc = cyc;
            r_cnt = 0;
            if (fixed_dly) begin
                r_ack = 1; r_dst = 3; r_rdy = 4;
            end else begin
                r_ack = $urandom_range(1, 3);
                r_dst = r_ack + $urandom_range(1, 3);
                r_rdy = r_dst + $urandom_range(0, 1);
            end
        end
    end

    txn_t  game_q[$];
    pexp_t pico_q[$];
    int    outstanding = 0;
    int    game_done_cyc = -1;
    int    pico_done_cyc = -1;

    initial forever begin
        txn_t  ge;
        pexp_t pe;
        @(negedge clk);
        if (!rst && game_rdy) begin
            if (game_q.size() == 0) begin
                fail_now("game_rdy_unexpected");
            end else begin
                ge = game_q.pop_front();
                chk("game_txn", 64'(last_txn), 64'(ge));
                game_done_cyc = cyc;
            end
        end
        if (!rst && pico_rdy) begin
            if (pico_q.size() == 0) begin
                fail_now("pico_rdy_unexpected");
            end else begin
                pe = pico_q.pop_front();
                chk("pico_txn", 64'(last_txn), 64'(pe.t));
                chk("pico_err", 64'(pico_err), 64'(pe.err));
                if (!pe.err && !pe.t.wr)
                    chk("pico_dout", 64'(pico_dout), 64'(mem_rd(pe.t.addr)));
                pico_done_cyc = cyc;
                outstanding--;
            end
        end
    end

    task automatic game_xfer(input logic wr, input logic [AW-1:0] a,
                             input logic [15:0] d, input logic [1:0] m);
        txn_t t;
        int   n;
        @(posedge clk); #1;
        t = {wr, a, d, m};
        game_q.push_back(t);
        game_addr = a; game_din = d; game_din_m = m;
        game_rd = !wr; game_wr = wr;
        n = 0;
        do begin @(negedge clk); n++; end while (!game_ack && n < 400);
        if (!game_ack) fail_now("game_ack_wait");
        @(posedge clk); #1;
        game_rd = 1'b0; game_wr = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!game_rdy && n < 100);
        if (!game_rdy) fail_now("game_rdy_wait");
    endtask

    task automatic game_rand();
        game_xfer(1'($urandom), AW'($urandom), 16'($urandom), 2'($urandom));
    endtask

    task automatic pico_issue(input logic wr, input logic [23:0] a,
                              input logic [15:0] d, input logic [1:0] m,
                              input logic err, output int c0);
        pexp_t pe;
        @(posedge clk); #1;
        c0 = cyc;
        pico_req = 1'b1; pico_wr = wr; pico_addr = a;
        pico_din = d; pico_din_m = m;
        if (!lock && outstanding == 0) begin
            pe.t = {wr, a[AW-1:0], d, m};
            pe.err = err;
            pico_q.push_back(pe);
            outstanding++;
        end
        @(posedge clk); #1;
        pico_req = 1'b0;
        pico_wr = 1'($urandom); pico_addr = 24'($urandom);
        pico_din = 16'($urandom); pico_din_m = 2'($urandom);
    endtask

    task automatic wait_pico(input int budget);
        int n = 0;
        while (outstanding != 0 && n < budget) begin @(negedge clk); n++; end
        if (outstanding != 0) begin
            fail_now("pico_done_wait");
            pico_q.delete();
            outstanding = 0;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    bit hammer;
    int c0, lat;

    initial begin
        rst = 1'b1;
        game_rd = 1'b1;
        pico_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ba0", 64'({ba0.rd, ba0.wr, ba0.addr, ba0.din, ba0.din_m}), 64'(0));
        chk("rst_pico", 64'({pico_busy, pico_rdy, pico_err, pico_dout}), 64'(0));
        chk("rst_game", 64'({game_ack, game_dst, game_rdy}), 64'(0));
        game_rd = 1'b0;
        pico_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // idle-bus cheat read with fixed controller timing
        mem[AW'(22'h001234)] = 16'hBEEF;
        fixed_dly = 1'b1;
        pico_issue(1'b0, 24'h001234, 16'h0000, 2'b00, 1'b0, c0);
        @(negedge clk);
        chk("t1_busy", 64'(pico_busy), 64'(1));
        wait_pico(50);
        chk("t1_grant_lat", 64'(cap_cyc - c0), 64'(2));
        chk("t1_rdy_lat", 64'(pico_done_cyc - c0), 64'(7));
        chk("t1_busy_clr", 64'(pico_busy), 64'(0));
        chk("t1_dout", 64'(pico_dout), 64'(16'hBEEF));
        @(negedge clk);
        chk("t1_rdy_pulse", 64'(pico_rdy), 64'(0));
        fixed_dly = 1'b0;

        // starvation guard under continuous game traffic
        hammer = 1'b1;
        fork
            begin
                while (hammer) game_rand();
            end
            begin
                repeat (3) @(posedge clk);
                pico_issue(1'b0, 24'($urandom), 16'($urandom), 2'($urandom), 1'b0, c0);
                wait_pico(300);
                lat = pico_done_cyc - c0;
                chk("t2_lat_lo", 64'(lat >= MAXWAIT), 64'(1));
                chk("t2_lat_hi", 64'(lat <= MAXWAIT + 40), 64'(1));
                hammer = 1'b0;
            end
        join
        repeat (3) @(posedge clk);

        // game and cheat requested in the same cycle
        game_done_cyc = -1;
        fork
            game_xfer(1'b1, AW'(22'h2AAAA), 16'h1357, 2'b10);
            pico_issue(1'b1, 24'hC05555, 16'h2468, 2'b01, 1'b0, c0);
        join
        wait_pico(100);
        chk("t3_order", 64'(game_done_cyc >= 0 && game_done_cyc < pico_done_cyc), 64'(1));
        repeat (3) @(posedge clk);

        // lost ba0_rdy
        drop_rdy = 1'b1;
        pico_issue(1'b0, 24'h00ABCD, 16'h0000, 2'b11, 1'b1, c0);
        wait_pico(TOUT + 50);
        chk("t4_tout_lat", 64'(pico_done_cyc - cap_cyc), 64'(TOUT));
        drop_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", 64'(pico_err), 64'(1));
        chk("t4_busy_clr", 64'(pico_busy), 64'(0));
        pico_issue(1'b1, 24'h000777, 16'hA5A5, 2'b00, 1'b0, c0);
        @(negedge clk);
        chk("t4_err_clr", 64'(pico_err), 64'(0));
        wait_pico(100);

        // locked port drops requests
        lock = 1'b1;
        pico_issue(1'b1, 24'h001111, 16'h4321, 2'b00, 1'b0, c0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_idle", 64'({pico_busy, ba0.rd, ba0.wr}), 64'(0));
        end
        lock = 1'b0;

        // reset in the middle of a cheat transfer
        fixed_dly = 1'b1;
        pico_issue(1'b0, 24'h003333, 16'h0000, 2'b00, 1'b0, c0);
        lat = 0;
        while (!ba0.rd && lat < 20) begin @(negedge clk); lat++; end
        if (!ba0.rd) fail_now("t6_rd_wait");
        #2 rst = 1'b1;
        #1;
        chk("t6_rd_async", 64'({ba0.rd, ba0.wr}), 64'(0));
        chk("t6_busy_async", 64'(pico_busy), 64'(0));
        pico_q.delete();
        outstanding = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fixed_dly = 1'b0;
        game_xfer(1'b0, AW'(22'h012345), 16'h0000, 2'b00);
        @(posedge clk);
        chk("t6_game_served", 64'(game_q.size()), 64'(0));

        // randomized mix of game and cheat traffic
        fork
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    game_rand();
                end
            end
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    lock = ($urandom_range(0, 5) == 0);
                    pico_issue(1'($urandom), 24'($urandom), 16'($urandom),
                               2'($urandom), 1'b0, c0);
                    if ($urandom_range(0, 1) == 1) begin
                        lock = 1'($urandom);
                        pico_issue(1'($urandom), 24'($urandom), 16'($urandom),
                                   2'($urandom), 1'b0, c0);
                    end
                    wait_pico(400);
                    lock = 1'b0;
                end
            end
        join

        repeat (10) @(posedge clk);
        chk("final_game_q", 64'(game_q.size()), 64'(0));
        chk("final_pico_q", 64'(pico_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
